// File: rtl/ram_dumper.sv
// RAM-to-UART hex dumper: fetches bytes from address 0 upward and pushes them
// out as uppercase hex pairs, space/newline separated, ending with EOF (0x04).

package pkg_ram;
    localparam int RAM_ADDRW     = 16;
    localparam int RAM_QUAD_SIZE = 32;

    typedef enum logic [1:0] {
        RAM_NOP   = 2'd0,
        RAM_FETCH = 2'd1,
        RAM_STORE = 2'd2
    } ram_op_t;

    typedef enum logic [1:0] {
        RAM_BYTE = 2'd0,
        RAM_HALF = 2'd1,
        RAM_QUAD = 2'd2
    } ram_data_type_t;
endpackage

module ram_dumper #(
    parameter int RAM_ADDRW      = pkg_ram::RAM_ADDRW,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [RAM_ADDRW-1:0]                len,
    output logic                                busy,
    output logic                                done,
    output pkg_ram::ram_op_t                    ram_op,
    output pkg_ram::ram_data_type_t             ram_data_type,
    output logic [RAM_ADDRW-1:0]                ram_addr,
    input  logic [pkg_ram::RAM_QUAD_SIZE-1:0]   ram_data_out,
    input  logic                                putc_en,
    output logic                                putc_push,
    output logic [7:0]                          putc_char
);
    import pkg_ram::*;

    localparam int LINEW = $clog2(BYTES_PER_LINE) + 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, HI, LO, SEP, EOF, DONE
    } state_t;

    state_t               state, state_n;
    logic [RAM_ADDRW-1:0] len_q, len_n;
    logic [RAM_ADDRW-1:0] addr, addr_n;
    logic [LINEW-1:0]     line_cnt, line_n;
    logic [7:0]           data_byte, data_byte_n;
    logic                 gap, gap_n;
    logic                 busy_n, done_n, push_n;
    logic [7:0]           char_n;
    ram_op_t              ram_op_n;

    logic                 last_byte;
    logic                 line_full;
    logic [LINEW-1:0]     line_inc;
    logic                 unused_ram_bits;

    function automatic logic [7:0] hex_digit(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Full-width compare so a length of all ones still terminates correctly.
    assign last_byte       = (addr == len_q - RAM_ADDRW'(1));
    assign line_inc        = line_cnt + LINEW'(1);
    assign line_full       = (line_inc == LINEW'(BYTES_PER_LINE));
    assign ram_addr        = addr;
    assign ram_data_type   = RAM_BYTE;
    assign unused_ram_bits = ^ram_data_out[RAM_QUAD_SIZE-1:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            addr      <= '0;
            line_cnt  <= '0;
            data_byte <= '0;
            gap       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            putc_push <= 1'b0;
            putc_char <= '0;
            ram_op    <= RAM_NOP;
        end else begin
            state     <= state_n;
            len_q     <= len_n;
            addr      <= addr_n;
            line_cnt  <= line_n;
            data_byte <= data_byte_n;
            gap       <= gap_n;
            busy      <= busy_n;
            done      <= done_n;
            putc_push <= push_n;
            putc_char <= char_n;
            ram_op    <= ram_op_n;
        end
    end

    // Push states cycle through: wait for putc_en, push, one gap cycle, advance.
    always_comb begin
        state_n     = state;
        len_n       = len_q;
        addr_n      = addr;
        line_n      = line_cnt;
        data_byte_n = data_byte;
        gap_n       = gap;
        busy_n      = busy;
        done_n      = done;
        push_n      = 1'b0;
        char_n      = putc_char;
        ram_op_n    = RAM_NOP;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    len_n  = len;
                    addr_n = '0;
                    line_n = '0;
                    gap_n  = 1'b0;
                    busy_n = 1'b1;
                    done_n = 1'b0;
                    if (len == '0) begin
                        state_n = EOF;
                        char_n  = 8'h04;
                        push_n  = putc_en;
                    end else begin
                        state_n  = FETCH;
                        ram_op_n = RAM_FETCH;
                    end
                end
            end
            FETCH: begin
                state_n = WAIT;
            end
            WAIT: begin
                data_byte_n = ram_data_out[7:0];
                char_n      = hex_digit(ram_data_out[7:4]);
                push_n      = putc_en;
                state_n     = HI;
            end
            HI, LO, SEP, EOF: begin
                if (putc_push) begin
                    gap_n = 1'b1;
                end else if (!gap) begin
                    push_n = putc_en;
                end else begin
                    gap_n = 1'b0;
                    case (state)
                        HI: begin
                            state_n = LO;
                            char_n  = hex_digit(data_byte[3:0]);
                            push_n  = putc_en;
                        end
                        LO: begin
                            state_n = SEP;
                            push_n  = putc_en;
                            if (last_byte || line_full) begin
                                char_n = 8'h0A;
                                line_n = '0;
                            end else begin
                                char_n = 8'h20;
                                line_n = line_inc;
                            end
                        end
                        SEP: begin
                            addr_n = addr + RAM_ADDRW'(1);
                            if (last_byte) begin
                                state_n = EOF;
                                char_n  = 8'h04;
                                push_n  = putc_en;
                            end else begin
                                state_n  = FETCH;
                                ram_op_n = RAM_FETCH;
                            end
                        end
                        default: begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_dumper.sv
// Self-checking bench for ram_dumper: a byte-array RAM model, a push monitor,
// and a reference model that formats the expected hex dump directly.

module tb_ram_dumper;
    import pkg_ram::*;

    localparam int AW  = pkg_ram::RAM_ADDRW;
    localparam int BPL = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [AW-1:0]            len;
    logic                     busy;
    logic                     done;
    ram_op_t                  ram_op;
    ram_data_type_t           ram_data_type;
    logic [AW-1:0]            ram_addr;
    logic [RAM_QUAD_SIZE-1:0] ram_data_out;
    logic                     putc_en;
    logic                     putc_push;
    logic [7:0]               putc_char;

    ram_dumper #(.RAM_ADDRW(AW), .BYTES_PER_LINE(BPL)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done),
        .ram_op(ram_op), .ram_data_type(ram_data_type), .ram_addr(ram_addr),
        .ram_data_out(ram_data_out),
        .putc_en(putc_en), .putc_push(putc_push), .putc_char(putc_char)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:1023];
    int cyc = 0;
    int t1 = 0;
    logic [7:0]    got[$];
    logic [7:0]    exp_q[$];
    int            push_t[$];
    int            fetch_t[$];
    logic [AW-1:0] fetch_addr[$];
    int            bad_push = 0;
    int            dbl_fetch = 0;
    bit            prev_fetch = 1'b0;
    string         hexs = "0123456789ABCDEF";

    bit stall_mode = 1'b0;
    int stall_left = 0;
    int low_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM: data is only meaningful the cycle after a fetch.
    always @(posedge clk) begin
        if (ram_op == RAM_FETCH)
            ram_data_out <= {8'($urandom), 8'($urandom), 8'($urandom), mem[ram_addr[9:0]]};
        else
            ram_data_out <= $urandom;
    end

    always @(negedge clk) begin
        if (putc_push === 1'b1) begin
            got.push_back(putc_char);
            push_t.push_back(cyc);
            if (putc_en !== 1'b1) bad_push++;
        end
        if (ram_op == RAM_FETCH) begin
            fetch_addr.push_back(ram_addr);
            fetch_t.push_back(cyc);
            if (prev_fetch) dbl_fetch++;
        end
        prev_fetch = (ram_op == RAM_FETCH);
    end

    // Output-buffer back-pressure: only drops putc_en in a cycle without a push.
    always @(negedge clk) begin
        if (stall_mode) begin
            if (putc_en == 1'b0) begin
                low_run--;
                if (low_run <= 0) putc_en = 1'b1;
            end else if (stall_left > 0 && putc_push !== 1'b1 && $urandom_range(0, 3) == 0) begin
                low_run = $urandom_range(1, 5);
                if (low_run > stall_left) low_run = stall_left;
                stall_left -= low_run;
                putc_en = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic void model_dump(input int n);
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = mem[i];
            exp_q.push_back(hexs[b[7:4]]);
            exp_q.push_back(hexs[b[3:0]]);
            exp_q.push_back((i == n - 1 || (i % BPL) == BPL - 1) ? 8'h0A : 8'h20);
        end
        exp_q.push_back(8'h04);
    endfunction

    function automatic string q2hex(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h", q[i])};
        return s;
    endfunction

    task automatic clear_logs();
        got.delete();
        push_t.delete();
        fetch_t.delete();
        fetch_addr.delete();
    endtask

    task automatic pulse_start(input logic [AW-1:0] l);
        @(negedge clk);
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t1    = cyc;
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        n  = 1;
        ok = 1'b0;
        while (n <= budget) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; putc_en = 1'b1; len = '0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        vectors++; if (putc_push !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_push: got %b, expected 0", putc_push); end
        vectors++; if (putc_char !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_char: got %h, expected 00", putc_char); end
        vectors++; if (ram_op !== RAM_NOP) begin miscompares++; $display("[TB] FAIL reset_ram_op: got %0d, expected %0d", ram_op, RAM_NOP); end
        vectors++; if (ram_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h, expected 0", ram_addr); end
        vectors++; if (ram_data_type !== RAM_BYTE) begin miscompares++; $display("[TB] FAIL data_type: got %0d, expected %0d", ram_data_type, RAM_BYTE); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n; bit ok;
        mem[0] = 8'h00; mem[1] = 8'hAB; mem[2] = 8'hFF;
        clear_logs();
        pulse_start(AW'(3));
        wait_done(200, n, ok);
        exp_q = '{8'h30, 8'h30, 8'h20, 8'h41, 8'h42, 8'h20, 8'h46, 8'h46, 8'h0A, 8'h04};
        vectors++; if (!ok || n != 27) begin miscompares++; $display("[TB] FAIL basic_done_cycle: got k+%0d (seen=%0b), expected k+27", n, ok); end
        vectors++; if (fetch_t.size() < 1 || fetch_t[0] - t1 + 1 != 1) begin miscompares++; $display("[TB] FAIL basic_fetch_cycle: got %0d fetches, expected first at k+1", fetch_t.size()); end
        vectors++; if (push_t.size() < 1 || push_t[0] - t1 + 1 != 3) begin miscompares++; $display("[TB] FAIL basic_push_cycle: got %0d pushes, expected first at k+3", push_t.size()); end
        vectors++; if (q2hex(got) != q2hex(exp_q)) begin miscompares++; $display("[TB] FAIL basic_stream: got %s, expected %s", q2hex(got), q2hex(exp_q)); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_after: got %b, expected 0", busy); end
    endtask

    task automatic test_len0();
        int n; bit ok;
        clear_logs();
        pulse_start('0);
        wait_done(50, n, ok);
        repeat (3) @(negedge clk);
        vectors++; if (!ok || n != 3) begin miscompares++; $display("[TB] FAIL len0_done_cycle: got k+%0d (seen=%0b), expected k+3", n, ok); end
        vectors++; if (got.size() != 1 || got[0] !== 8'h04) begin miscompares++; $display("[TB] FAIL len0_stream: got %s, expected 04", q2hex(got)); end
        vectors++; if (push_t.size() < 1 || push_t[0] - t1 + 1 != 1) begin miscompares++; $display("[TB] FAIL len0_push_cycle: got %0d pushes, expected push at k+1", push_t.size()); end
        vectors++; if (fetch_t.size() != 0) begin miscompares++; $display("[TB] FAIL len0_fetches: got %0d, expected 0", fetch_t.size()); end
    endtask

    task automatic test_line_break();
        int n; bit ok;
        for (int i = 0; i < 17; i++) mem[i] = 8'(i);
        clear_logs();
        model_dump(17);
        pulse_start(AW'(17));
        wait_done(400, n, ok);
        vectors++; if (got.size() != 52) begin miscompares++; $display("[TB] FAIL line_count: got %0d chars, expected 52", got.size()); end
        vectors++; if (got.size() < 52 || got[45] !== 8'h30 || got[46] !== 8'h46 || got[47] !== 8'h0A) begin miscompares++; $display("[TB] FAIL line_break16: got %s, expected 0F then newline", q2hex(got)); end
        vectors++; if (got.size() < 52 || got[48] !== 8'h31 || got[49] !== 8'h30 || got[50] !== 8'h0A || got[51] !== 8'h04) begin miscompares++; $display("[TB] FAIL line_tail: got %s, expected 10 newline EOF", q2hex(got)); end
        vectors++; if (q2hex(got) != q2hex(exp_q)) begin miscompares++; $display("[TB] FAIL line_stream: got %s, expected %s", q2hex(got), q2hex(exp_q)); end
    endtask

    task automatic test_random_lengths();
        int n; bit ok; int l;
        for (int r = 0; r < 4; r++) begin
            l = $urandom_range(1, 20);
            for (int i = 0; i < l; i++) mem[i] = 8'($urandom);
            clear_logs();
            model_dump(l);
            pulse_start(AW'(l));
            wait_done(400, n, ok);
            vectors++; if (!ok || n != 8 * l + 3) begin miscompares++; $display("[TB] FAIL rand_done_cycle: len %0d got k+%0d (seen=%0b), expected k+%0d", l, n, ok, 8 * l + 3); end
            vectors++; if (q2hex(got) != q2hex(exp_q)) begin miscompares++; $display("[TB] FAIL rand_stream: len %0d got %s, expected %s", l, q2hex(got), q2hex(exp_q)); end
        end
    endtask

    task automatic test_stall();
        int n; bit ok; int bad0;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        clear_logs();
        model_dump(4);
        bad0       = bad_push;
        stall_left = 20;
        low_run    = 0;
        stall_mode = 1'b1;
        pulse_start(AW'(4));
        wait_done(400, n, ok);
        stall_mode = 1'b0;
        putc_en    = 1'b1;
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL stall_done: got done=%b, expected 1 within budget", done); end
        vectors++; if (q2hex(got) != q2hex(exp_q)) begin miscompares++; $display("[TB] FAIL stall_stream: got %s, expected %s", q2hex(got), q2hex(exp_q)); end
        vectors++; if (bad_push != bad0) begin miscompares++; $display("[TB] FAIL stall_push_while_blocked: got %0d, expected 0", bad_push - bad0); end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; bit found; int gs; int fs;
        for (int i = 0; i < 5; i++) mem[i] = 8'($urandom);
        clear_logs();
        pulse_start(AW'(5));
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (ram_op == RAM_FETCH && ram_addr == AW'(1)) found = 1'b1;
            else @(negedge clk);
        end
        vectors++; if (!found) begin miscompares++; $display("[TB] FAIL mid_second_fetch: got none, expected fetch of addr 1"); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b, expected 0", busy); end
        vectors++; if (putc_push !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_push: got %b, expected 0", putc_push); end
        vectors++; if (ram_op !== RAM_NOP) begin miscompares++; $display("[TB] FAIL mid_ram_op: got %0d, expected %0d", ram_op, RAM_NOP); end
        gs = got.size();
        fs = fetch_t.size();
        repeat (30) @(negedge clk);
        vectors++; if (got.size() != gs || fetch_t.size() != fs) begin miscompares++; $display("[TB] FAIL mid_quiet: got %0d pushes %0d fetches, expected none", got.size() - gs, fetch_t.size() - fs); end
        clear_logs();
        model_dump(2);
        pulse_start(AW'(2));
        wait_done(200, n, ok);
        vectors++; if (fetch_addr.size() < 1 || fetch_addr[0] !== '0) begin miscompares++; $display("[TB] FAIL mid_restart_addr: got %0d fetches, expected first at addr 0", fetch_addr.size()); end
        vectors++; if (q2hex(got) != q2hex(exp_q)) begin miscompares++; $display("[TB] FAIL mid_restart_stream: got %s, expected %s", q2hex(got), q2hex(exp_q)); end
    endtask

    task automatic test_back_to_back();
        int n; bit ok;
        for (int i = 0; i < 9; i++) mem[i] = 8'($urandom);
        clear_logs();
        model_dump(3);
        pulse_start(AW'(3));
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            len   = AW'(9);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(200, n, ok);
        vectors++; if (q2hex(got) != q2hex(exp_q)) begin miscompares++; $display("[TB] FAIL busy_start_stream: got %s, expected %s", q2hex(got), q2hex(exp_q)); end
        vectors++; if (fetch_t.size() != 3) begin miscompares++; $display("[TB] FAIL busy_start_fetches: got %0d, expected 3", fetch_t.size()); end
        clear_logs();
        model_dump(2);
        pulse_start(AW'(2));
        vectors++; if (done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_flags: got done=%b busy=%b, expected done=0 busy=1", done, busy); end
        wait_done(200, n, ok);
        vectors++; if (!ok || n != 19) begin miscompares++; $display("[TB] FAIL restart_done_cycle: got k+%0d (seen=%0b), expected k+19", n, ok); end
        vectors++; if (q2hex(got) != q2hex(exp_q)) begin miscompares++; $display("[TB] FAIL restart_stream: got %s, expected %s", q2hex(got), q2hex(exp_q)); end
    endtask

    task automatic test_protocol();
        vectors++; if (dbl_fetch != 0) begin miscompares++; $display("[TB] FAIL consecutive_fetch: got %0d, expected 0", dbl_fetch); end
        vectors++; if (bad_push != 0) begin miscompares++; $display("[TB] FAIL push_without_en: got %0d, expected 0", bad_push); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_line_break();
        test_random_lengths();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_dumper.md
# ram_dumper

Reads a contiguous byte range from RAM, starting at address 0, and sends it out of the UART as a hex dump. It sits between the RAM client port and the putc side of the IO block, and is the transmit-side counterpart of the UART-to-RAM loader. It lets the host read back what was loaded. The dump text is uppercase hex bytes separated by spaces, broken into lines, and terminated by EOF (0x04).

## Interface

Parameters:
- RAM_ADDRW, default pkg_ram::RAM_ADDRW: RAM address width.
- BYTES_PER_LINE, default 16: bytes per output line. Must be at least 1.

Ports:
- clk  in  1: the single clock.
- rst  in  1: synchronous, active-high reset.
- start  in  1: a one-cycle pulse that begins a dump. Ignored while busy.
- len  in  RAM_ADDRW: number of bytes to dump. Sampled on the accepted start.
- busy  out  1: high from the cycle after an accepted start until the EOF push completes.
- done  out  1: set when the dump finishes. Held high until the next accepted start or reset.
- ram_op  out  pkg_ram op type: RAM_FETCH for one cycle per byte, RAM_NOP otherwise.
- ram_data_type  out  pkg_ram type: constant RAM_BYTE.
- ram_addr  out  RAM_ADDRW: fetch address.
- ram_data_out  in  RAM_QUAD_SIZE: RAM read data. Only bits [7:0] are used.
- putc_en  in  1: IO output buffer can accept a character.
- putc_push  out  1: one-cycle push strobe.
- putc_char  out  8: character to push. Valid in the push cycle.

## Operation

- States: IDLE, FETCH, WAIT, HI, LO, SEP, EOF, DONE.
- **IDLE/DONE:**
  - When start is high: latch len, clear the address counter, clear done.
  - If len == 0, go to EOF. Otherwise go to FETCH.
- **FETCH:** drive ram_op=RAM_FETCH and ram_addr=counter for exactly one cycle, then go to WAIT.
- **WAIT:** capture ram_data_out[7:0] into the byte register at the end of the cycle, then go to HI.
- **HI:** push the ASCII hex digit of byte[7:4]. Nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46. Then go to LO.
- **LO:** push the hex digit of byte[3:0], then go to SEP.
- **SEP:**
  - If this was the last byte, or the line byte count has reached BYTES_PER_LINE, push "\n" (0x0A) and reset the line count.
  - Otherwise push " " (0x20).
  - Then increment the address. Go to EOF if it was the last byte, otherwise go to FETCH.
- **EOF:** push 0x04, set done, go to DONE.
- Push rule (applies in every push state):
  - putc_push is asserted only in a cycle where putc_en is high.
  - After each push, insert one gap cycle with putc_push low before the next push or state action. This lets putc_en reflect the new fill level.
  - While putc_en is low, hold the state and putc_char, and keep putc_push low.
- Arithmetic:
  - The address counter is RAM_ADDRW wide.
  - "Last byte" means counter == len-1, compared at full width, so len = 2^RAM_ADDRW-1 is supported.
  - The line counter is log2(BYTES_PER_LINE)+1 bits wide.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0: ram_op=RAM_NOP, ram_addr=0, putc_push=0, putc_char=0, busy=0, done=0.
  - A reset mid-dump aborts it at once. No further pushes or fetches occur.
- start while busy is ignored. start in DONE restarts the dump.

## Timing

- All outputs are registered.
- start sampled high at edge k:
  - ram_op=RAM_FETCH is visible during cycle k+1.
  - RAM data is valid in cycle k+2 and captured at that edge.
  - The first putc_push is in cycle k+3, if putc_en=1.
- With putc_en held at 1, each byte takes 8 cycles: FETCH, WAIT, then three pushes of 2 cycles each (push cycle plus gap).
  - Total from start to done = 8·len + 3 cycles.
  - len=0: 0x04 is pushed in cycle k+1, and done rises at k+3.
- busy and done change in the same cycle, at the end of the EOF gap cycle.
- ram_op is never FETCH on two consecutive cycles.

## Test plan

- RAM[0..2]=0x00,0xAB,0xFF, len=3, putc_en=1 → chars "0","0"," ","A","B"," ","F","F","\n",0x04. done=1 at cycle k+27.
- len=0 → exactly one push (0x04). No RAM_FETCH ever issued. done=1.
- len=17, BYTES_PER_LINE=16, RAM[i]=i:
  - "\n" after "0F".
  - 17th byte "10" followed by "\n", then 0x04.
  - 51 hex/separator chars plus EOF in total.
- len=4, putc_en toggled low for 20 cycles at random points → the pushed stream is identical to the putc_en=1 run. No push ever occurs while putc_en=0. No duplicate or dropped chars.
- rst=1 for one cycle during the 2nd byte → next cycle: busy=0, putc_push=0, ram_op=NOP. No push until a new start, and a fresh dump then starts at address 0.
- start pulsed again while busy → ignored; output stream unchanged. start in DONE → full dump repeats and done drops for its duration.
